pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the three-stage I/X/M pipeline. It merges instruction-cache and data-cache wait signals and stage-X control-flow redirects into one `stall` line, a wrong-path `flush_i` strobe and a `pipe_reset` line. Every inter-stage transfer register and the PC register consume these outputs. It also runs a post-reset NOP-fill sequence so that no transfer register leaves reset with stale contents.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_perf_cnt.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM encodings and pipeline constants for the
// hazard sequencer and the pipeline transfer registers.
package pipe_hazard_ctrl_pkg;

   // Raw 2-bit state encodings, kept visible for the transfer-register code
   localparam logic [1:0] PHC_INIT        = 2'd0;
   localparam logic [1:0] PHC_RUN         = 2'd1;
   localparam logic [1:0] PHC_STALL       = 2'd2;
   localparam logic [1:0] PHC_STALL_FLUSH = 2'd3;

   typedef enum logic [1:0] {
      ST_INIT        = PHC_INIT,
      ST_RUN         = PHC_RUN,
      ST_STALL       = PHC_STALL,
      ST_STALL_FLUSH = PHC_STALL_FLUSH
   } phc_state_e;

   // NOP loaded by the transfer registers on flush/pipe_reset; this block
   // never drives instruction bits itself
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// pipe_perf_cnt: wrapping event counter with synchronous clear.
// Only compiled when PIPE_PERF_EN is defined.
`ifdef PIPE_PERF_EN
module pipe_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // next count: wraps naturally at 2^CNT_W
   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + CNT_W'(1);
   end

   // counter register, synchronous clear
   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/pipe_reset sequencer for the I/X/M pipeline.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int INIT_CYCLES = 2
`ifdef PIPE_PERF_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   input  logic             redirect,
   output logic             stall,
   output logic             flush_i,
   output logic             pipe_reset
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [3:0] INIT_LD = 4'(INIT_CYCLES);

   phc_state_e state_q, state_d;
   logic [3:0] init_cnt_q, init_cnt_d;
   logic       cache_stall;
   logic       stall_c, flush_c, pipe_reset_c;

   assign cache_stall = icache_stall | dcache_stall;

   // next-state and output decode; outputs are combinational from inputs
   // and the registered state so a cache wait freezes the pipe immediately
   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      stall_c      = 1'b0;
      flush_c      = 1'b0;
      pipe_reset_c = 1'b0;
      case (state_q)
         ST_INIT: begin
            // cache waits are meaningless while NOPs are being filled
            stall_c      = 1'b1;
            pipe_reset_c = 1'b1;
            if (init_cnt_q != 4'd0) init_cnt_d = init_cnt_q - 4'd1;
            // the counter hits zero on the same edge that enters RUN
            if (init_cnt_q <= 4'd1) state_d = ST_RUN;
         end
         ST_RUN: begin
            stall_c = cache_stall;
            flush_c = redirect & ~cache_stall;
            if (cache_stall) state_d = redirect ? ST_STALL_FLUSH : ST_STALL;
         end
         ST_STALL: begin
            stall_c = cache_stall;
            if (cache_stall) begin
               if (redirect) state_d = ST_STALL_FLUSH;
            end else begin
               // a redirect arriving in the release cycle flushes right here
               flush_c = redirect;
               state_d = ST_RUN;
            end
         end
         ST_STALL_FLUSH: begin
            stall_c = cache_stall;
            if (!cache_stall) begin
               // redirect may already have dropped; the flush is owed anyway
               flush_c = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            stall_c      = 1'b1;
            pipe_reset_c = 1'b1;
            state_d      = ST_INIT;
         end
      endcase
   end

   // state register; reset reloads the NOP-fill length from any state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= INIT_LD;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   assign stall      = stall_c;
   // a flush pending across reset is superseded by the NOP fill
   assign flush_i    = flush_c & ~reset;
   assign pipe_reset = pipe_reset_c;

`ifdef PIPE_PERF_EN
   logic in_init;
   assign in_init = (state_q == ST_INIT);

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~in_init),
      .count (cycle_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall & ~in_init),
      .count (stall_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_i),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
// Counter checks are compiled only when PIPE_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

   typedef struct {
      string tag;
      logic  stall;
      logic  flush;
      logic  prst;
   } exp_t;

   logic clk = 1'b0;
   logic reset, icache_stall, dcache_stall, redirect;
   logic stall, flush_i, pipe_reset;
`ifdef PIPE_PERF_EN
   logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   pipe_hazard_ctrl #(.INIT_CYCLES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .icache_stall (icache_stall),
      .dcache_stall (dcache_stall),
      .redirect     (redirect)
      ,
      .stall        (stall),
      .flush_i      (flush_i),
      .pipe_reset   (pipe_reset)
`ifdef PIPE_PERF_EN
      ,
      .cycle_cnt    (cycle_cnt),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // one cycle: drive after the posedge, push expectation, compare at negedge
   task automatic step(input string tag, input logic rst, input logic ic,
                       input logic dc, input logic rd, input logic e_stall,
                       input logic e_flush, input logic e_prst);
      exp_t e;
      reset = rst; icache_stall = ic; dcache_stall = dc; redirect = rd;
      e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.prst = e_prst;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      assert (stall === e.stall) else begin
         errors++;
         $error("FAIL %s.stall got=%b exp=%b", e.tag, stall, e.stall);
      end
      checks++;
      assert (flush_i === e.flush) else begin
         errors++;
         $error("FAIL %s.flush_i got=%b exp=%b", e.tag, flush_i, e.flush);
      end
      checks++;
      assert (pipe_reset === e.prst) else begin
         errors++;
         $error("FAIL %s.pipe_reset got=%b exp=%b", e.tag, pipe_reset, e.prst);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; icache_stall = 1'b0; dcache_stall = 1'b0; redirect = 1'b0;
      @(posedge clk);
      #1;
      //        tag       rst ic dc rd  stall flush prst
      step("rst0",    1, 0, 0, 0,  1, 0, 1);
      step("rst1",    1, 0, 0, 0,  1, 0, 1);
      step("rst2",    1, 0, 0, 0,  1, 0, 1);
      // init fill; cache stall during INIT is ignored
      step("init1",   0, 1, 0, 0,  1, 0, 1);
      step("init2",   0, 0, 1, 0,  1, 0, 1);
`ifdef PIPE_PERF_EN
      reset = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0; redirect = 1'b0;
      @(negedge clk);
      chk_cnt("cycle_cnt.after_init", cycle_cnt, 32'd0);
      @(posedge clk);
      #1;
      sb.push_back('{tag: "run0.dummy", stall: 1'b0, flush: 1'b0, prst: 1'b0});
      void'(sb.pop_front());
`else
      step("run0",    0, 0, 0, 0,  0, 0, 0);
`endif
      // dcache stall for 4 cycles
      step("dc1",     0, 0, 1, 0,  1, 0, 0);
      step("dc2",     0, 0, 1, 0,  1, 0, 0);
      step("dc3",     0, 0, 1, 0,  1, 0, 0);
      step("dc4",     0, 0, 1, 0,  1, 0, 0);
`ifdef PIPE_PERF_EN
      chk_cnt("stall_cnt.dc", stall_cnt, 32'd4);
      chk_cnt("cycle_cnt.dc", cycle_cnt, 32'd5);
`endif
      step("dc_rel",  0, 0, 0, 0,  0, 0, 0);
      // redirect raised and dropped while icache stalled
      step("ic1",     0, 1, 0, 0,  1, 0, 0);
      step("ic2",     0, 1, 0, 1,  1, 0, 0);
      step("ic3",     0, 1, 0, 0,  1, 0, 0);
      step("ic_rel",  0, 0, 0, 0,  0, 1, 0);
      step("ic_post", 0, 0, 0, 0,  0, 0, 0);
`ifdef PIPE_PERF_EN
      chk_cnt("flush_cnt.ic", flush_cnt, 32'd1);
`endif
      // redirect and dcache stall in the same RUN cycle
      step("rs1",     0, 0, 1, 1,  1, 0, 0);
      step("rs2",     0, 0, 1, 1,  1, 0, 0);
      step("rs_rel",  0, 0, 0, 1,  0, 1, 0);
      step("rs_post", 0, 0, 0, 0,  0, 0, 0);
      // redirect arriving in the release cycle of STALL
      step("rr1",     0, 0, 1, 0,  1, 0, 0);
      step("rr_rel",  0, 0, 0, 1,  0, 1, 0);
      step("rr_post", 0, 0, 0, 0,  0, 0, 0);
      // back-to-back redirects in RUN
      step("bb1",     0, 0, 0, 1,  0, 1, 0);
      step("bb2",     0, 0, 0, 1,  0, 1, 0);
      step("bb_post", 0, 0, 0, 0,  0, 0, 0);
`ifdef PIPE_PERF_EN
      chk_cnt("flush_cnt.bb", flush_cnt, 32'd5);
`endif
      // reset while a flush is pending in STALL_FLUSH
      step("rf1",     0, 0, 1, 1,  1, 0, 0);
      step("rf_rst",  1, 0, 1, 1,  1, 0, 0);
      step("rf_i1",   0, 0, 0, 1,  1, 0, 1);
      step("rf_i2",   0, 0, 0, 0,  1, 0, 1);
      step("rf_run",  0, 0, 0, 0,  0, 0, 0);
`ifdef PIPE_PERF_EN
      chk_cnt("flush_cnt.rf", flush_cnt, 32'd0);
      chk_cnt("cycle_cnt.rf", cycle_cnt, 32'd1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // safety net so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
